mult_seq: RTL and testbench

Iterative 32×32→64 shift-add multiplier sequencer for the 64-bit integer datapath. It owns one instance of the 64-bit ripple adder and sequences it over 32 cycles: one conditional accumulate per multiplier bit. Optionally, one extra negate pass handles signed operands. It sits beside the ALU and serves MULT/MULTU through a start/done handshake; HI/LO are taken from `product`.

---
 rtl/mult_seq_pkg.sv | 30 +++
 rtl/mult_seq_addercat.sv | 29 ++
 rtl/mult_seq.sv | 151 +++++++++++++++
 tb/tb_mult_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// Shared types and sizes for the iterative shift-add multiplier.
// Build option: MULT_SIGNED_EN adds the two's-complement negate pass (NEG state).
package mult_seq_pkg;

  localparam int unsigned MULT_ITER   = 32;
  localparam int unsigned MULT_CNT_W  = 5;
  localparam int unsigned MULT_PROD_W = 64;
  localparam int unsigned MULT_OP_W   = 32;

`ifdef MULT_SIGNED_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_NEG  = 2'd2,
    ST_DONE = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd3
  } state_e;
`endif

  // Magnitude of a two's-complement operand; -2^31 maps to 0x80000000 unsigned.
  function automatic logic [MULT_OP_W-1:0] mag32(input logic [MULT_OP_W-1:0] x);
    mag32 = x[MULT_OP_W-1] ? MULT_OP_W'(~x + MULT_OP_W'(1)) : x;
  endfunction

endpackage

// File: rtl/mult_seq_addercat.sv
// 64-bit ripple-carry adder shared by the multiplier sequencer.
// Ports: a_i, b_i (64) addends; cin_i carry-in; sum_c_o (64) sum; cout_c_o carry-out.
// Purely combinational, hence the _c suffix on both outputs.
module addercat
  import mult_seq_pkg::*;
(
  input  logic [MULT_PROD_W-1:0] a_i,
  input  logic [MULT_PROD_W-1:0] b_i,
  input  logic                   cin_i,
  output logic [MULT_PROD_W-1:0] sum_c_o,
  output logic                   cout_c_o
);

  logic [MULT_PROD_W:0] carry_c;

  // Bit-serial carry chain, one full adder per bit.
  always_comb begin
    carry_c    = '0;
    sum_c_o    = '0;
    carry_c[0] = cin_i;
    for (int i = 0; i < int'(MULT_PROD_W); i++) begin
      sum_c_o[i]   = a_i[i] ^ b_i[i] ^ carry_c[i];
      carry_c[i+1] = (a_i[i] & b_i[i]) | (a_i[i] & carry_c[i]) | (b_i[i] & carry_c[i]);
    end
  end

  assign cout_c_o = carry_c[MULT_PROD_W];

endmodule

// File: rtl/mult_seq.sv
// Iterative 32x32->64 shift-add multiplier: one conditional accumulate per
// multiplier bit through a single shared 64-bit ripple adder.
// Ports: clk, rst_n (async, active low); start request; a multiplicand, b multiplier;
//        busy (CALC/NEG), done (one-cycle result pulse), product (64-bit result register).
// Build option: MULT_SIGNED_EN treats a/b as two's complement and adds a NEG pass.
module mult_seq
  import mult_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [MULT_OP_W-1:0]   a,
  input  logic [MULT_OP_W-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [MULT_PROD_W-1:0] product
);

  state_e                 state_q, state_d;
  logic [MULT_PROD_W-1:0] mcand_q, mcand_d;
  logic [MULT_OP_W-1:0]   mplier_q, mplier_d;
  logic [MULT_PROD_W-1:0] acc_q, acc_d;
  logic [MULT_CNT_W-1:0]  cnt_q, cnt_d;
  logic [MULT_PROD_W-1:0] product_q, product_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
`ifdef MULT_SIGNED_EN
  logic                   neg_q, neg_d;
`endif

  logic [MULT_PROD_W-1:0] add_a_c, add_b_c, add_sum_c;
  logic                   add_cin_c;
  // Carry-out cannot occur in CALC (partial sums never exceed the product); left unused.
  logic                   add_cout_unused;
  logic [MULT_OP_W-1:0]   op_a_c, op_b_c;

`ifdef MULT_SIGNED_EN
  assign op_a_c = mag32(a);
  assign op_b_c = mag32(b);
`else
  assign op_a_c = a;
  assign op_b_c = b;
`endif

  addercat u_add (
    .a_i      (add_a_c),
    .b_i      (add_b_c),
    .cin_i    (add_cin_c),
    .sum_c_o  (add_sum_c),
    .cout_c_o (add_cout_unused)
  );

  // Next-state, datapath and adder-input mux.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
`ifdef MULT_SIGNED_EN
    neg_d     = neg_q;
`endif
    add_a_c   = acc_q;
    add_b_c   = mplier_q[0] ? mcand_q : '0;
    add_cin_c = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mcand_d  = {{(MULT_PROD_W-MULT_OP_W){1'b0}}, op_a_c};
          mplier_d = op_b_c;
          acc_d    = '0;
          cnt_d    = '0;
`ifdef MULT_SIGNED_EN
          neg_d    = a[MULT_OP_W-1] ^ b[MULT_OP_W-1];
`endif
          state_d  = ST_CALC;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_CALC: begin
        acc_d    = add_sum_c;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + MULT_CNT_W'(1);
        if (cnt_q == MULT_CNT_W'(MULT_ITER - 1)) begin
`ifdef MULT_SIGNED_EN
          state_d   = ST_NEG;
`else
          product_d = add_sum_c;
          state_d   = ST_DONE;
`endif
        end
      end
`ifdef MULT_SIGNED_EN
      ST_NEG: begin
        // Two's-complement negate: ~acc + 0 + carry-in.
        add_a_c   = ~acc_q;
        add_b_c   = '0;
        add_cin_c = 1'b1;
        product_d = neg_q ? add_sum_c : acc_q;
        state_d   = ST_DONE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef MULT_SIGNED_EN
    busy_d = (state_d == ST_CALC) || (state_d == ST_NEG);
`else
    busy_d = (state_d == ST_CALC);
`endif
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MULT_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef MULT_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed, table-driven bench for mult_seq (unsigned or MULT_SIGNED_EN build).
module tb_mult_seq;
  import mult_seq_pkg::*;

`ifdef MULT_SIGNED_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 32;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a_s = '0;
  logic [31:0] b_s = '0;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int n_checks = 0;
  int n_fail   = 0;
  int cout_viol = 0;
  int overlap_viol = 0;

  mult_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a_s),
    .b       (b_s),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Continuous invariants: no adder carry-out while accumulating; busy/done exclusive.
  always @(negedge clk) begin
    if (rst_n && dut.state_q == ST_CALC && dut.add_cout_unused) cout_viol++;
    if (busy && done) overlap_viol++;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_u;
    logic [63:0] exp_s;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Drive a start request; returns just after the accepting edge.
  task automatic launch(input logic [31:0] ta, input logic [31:0] tb_v);
    a_s = ta; b_s = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen (bounded).
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin cyc = k; break; end
    end
  endtask

  vec_t vecs[10];
  int   cyc;
  int   ndone;

  initial begin
    vecs[0] = '{32'd3,        32'd5,        64'd15,                 64'd15};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001,  64'd1};
    vecs[2] = '{32'd0,        32'h12345678, 64'd0,                  64'd0};
    vecs[3] = '{32'd1,        32'hFFFFFFFF, 64'h00000000_FFFFFFFF,  64'hFFFFFFFF_FFFFFFFF};
    vecs[4] = '{32'h00010000, 32'h00010000, 64'h00000001_00000000,  64'h00000001_00000000};
    vecs[5] = '{32'h80000000, 32'd2,        64'h00000001_00000000,  64'hFFFFFFFF_00000000};
    vecs[6] = '{32'h80000000, 32'h80000000, 64'h40000000_00000000,  64'h40000000_00000000};
    vecs[7] = '{32'hFFFFFFFD, 32'd7,        64'h00000006_FFFFFFEB,  64'hFFFFFFFF_FFFFFFEB};
    vecs[8] = '{32'h12345678, 32'h10,       64'h00000001_23456780,  64'h00000001_23456780};
    vecs[9] = '{32'd1000,     32'd1000,     64'd1000000,            64'd1000000};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", product, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table: latency, result, and clean return to idle.
    for (int i = 0; i < 10; i++) begin
      logic [63:0] exp;
`ifdef MULT_SIGNED_EN
      exp = vecs[i].exp_s;
`else
      exp = vecs[i].exp_u;
`endif
      launch(vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_busy_after_start", i), 64'(busy), 64'd1);
      wait_done(cyc);
      check($sformatf("vec%0d_latency", i), 64'(cyc), 64'(LAT));
      check($sformatf("vec%0d_product", i), product, exp);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_single", i), 64'(done), 64'd0);
      check($sformatf("vec%0d_busy_idle", i), 64'(busy), 64'd0);
      check($sformatf("vec%0d_product_hold", i), product, exp);
    end

    // Start while busy is ignored.
    launch(32'd7, 32'd9);
    repeat (4) @(posedge clk);
    #1;
    a_s = 32'd1; b_s = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc);
    check("busy_start_latency", 64'(cyc + 5), 64'(LAT));
    check("busy_start_product", product, 64'd63);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("busy_start_no_second_done", 64'(ndone), 64'd0);
    check("busy_start_product_hold", product, 64'd63);

    // Reset in the middle of CALC.
    launch(32'd100, 32'd100);
    repeat (9) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_product", product, 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    check("midrst_no_done_busy", 64'(ndone), 64'd0);
    check("midrst_product_after", product, 64'd0);

    // Back-to-back: restart in the DONE cycle.
    launch(32'd2, 32'd3);
    wait_done(cyc);
    check("b2b_first_latency", 64'(cyc), 64'(LAT));
    check("b2b_first_product", product, 64'd6);
    launch(32'd4, 32'd4);
    check("b2b_busy_again", 64'(busy), 64'd1);
    check("b2b_product_held", product, 64'd6);
    wait_done(cyc);
    check("b2b_second_spacing", 64'(cyc + 1), 64'(LAT + 1));
    check("b2b_second_product", product, 64'd16);
    @(posedge clk); #1;
    check("b2b_idle", 64'(busy | done), 64'd0);

    // Invariants accumulated over the whole run.
    check("adder_carry_out_in_calc", 64'(cout_viol), 64'd0);
    check("busy_done_overlap", 64'(overlap_viol), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
